// File: rtl/prog_fir_pkg.sv
// Shared defaults, state encoding and request-bit position for the FIR coefficient loader.
package prog_fir_pkg;

  localparam int N_TAPS_DEF = 20;
  localparam int TAP_W_DEF  = 5;
  localparam int CHAN_W_DEF = 8;
  localparam int COEF_W_DEF = 18;
  localparam int RD_LAT_DEF = 2;
  localparam int REQ_BIT    = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } load_state_e;

endpackage

// File: rtl/prog_fir_tap_pipe.sv
// RD_LAT-deep {valid, tap} shift register that tracks staging reads in flight.
// Latency RD_LAT cycles from in_* to out_*; no backpressure, shifts every cycle.
module prog_fir_tap_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [TAP_W-1:0] in_tap,
  output logic             out_vld,
  output logic [TAP_W-1:0] out_tap,
  output logic             any_vld
);

  logic [RD_LAT-1:0]            vld_q, vld_d;
  logic [RD_LAT-1:0][TAP_W-1:0] tap_q, tap_d;

  always_comb begin
    vld_d    = vld_q;
    tap_d    = tap_q;
    vld_d[0] = in_vld;
    tap_d[0] = in_tap;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tap_d[i] = tap_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tap_q <= '0;
    end else begin
      vld_q <= vld_d;
      tap_q <= tap_d;
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_tap = tap_q[RD_LAT-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/prog_fir_coeff_loader.sv
// Copies one channel of staging-BRAM coefficients into the FIR coefficient RAM on a load_chan[31] edge.
// Latency: first write RD_LAT+2 cycles after the request edge; no backpressure, requests while busy are dropped.
module prog_fir_coeff_loader
  import prog_fir_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int TAP_W  = TAP_W_DEF,
  parameter int CHAN_W = CHAN_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [31:0]             load_chan,
  output logic [TAP_W-1:0]        stage_addr,
  input  logic [COEF_W-1:0]       stage_data,
  output logic                    coef_we,
  output logic [CHAN_W+TAP_W-1:0] coef_addr,
  output logic [COEF_W-1:0]       coef_data,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             done_count,
  output logic                    overrun
);

  localparam int DRN_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  load_state_e state_q, state_d;

  logic                    prev_q, prev_d;
  logic [CHAN_W-1:0]       chan_q, chan_d;
  logic [TAP_W-1:0]        stage_addr_q, stage_addr_d;
  logic                    issue_vld_q, issue_vld_d;
  logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                    coef_we_q, coef_we_d;
  logic [CHAN_W+TAP_W-1:0] coef_addr_q, coef_addr_d;
  logic [COEF_W-1:0]       coef_data_q, coef_data_d;
  logic                    done_q, done_d;
  logic [15:0]             done_count_q, done_count_d;
  logic                    overrun_q, overrun_d;

  logic             req_edge;
  logic             busy_int;
  logic             accept;
  logic             last_tap;
  logic             drain_last;
  logic             head_vld;
  logic [TAP_W-1:0] head_tap;
  logic             pipe_any;
  logic             unused_load_bits;

  assign unused_load_bits = ^load_chan[REQ_BIT-1:CHAN_W];

  // stage_addr_q is a live read only while issue_vld_q is set; the pipe starts from that registered pair
  prog_fir_tap_pipe #(
    .RD_LAT (RD_LAT),
    .TAP_W  (TAP_W)
  ) u_tap_pipe (
    .clk     (user_clk),
    .rst     (user_rst),
    .in_vld  (issue_vld_q),
    .in_tap  (stage_addr_q),
    .out_vld (head_vld),
    .out_tap (head_tap),
    .any_vld (pipe_any)
  );

  assign req_edge   = load_chan[REQ_BIT] && !prev_q;
  // the write register is the final stage of the load, so busy spans the done cycle
  assign busy_int   = (state_q != IDLE) || pipe_any || coef_we_q;
  assign accept     = req_edge && !busy_int;
  assign last_tap   = (stage_addr_q == TAP_W'(N_TAPS - 1));
  assign drain_last = (drain_cnt_q == DRN_W'(RD_LAT - 1));

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)     state_d = ISSUE;
      ISSUE:   if (last_tap)   state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    prev_d       = load_chan[REQ_BIT];
    chan_d       = chan_q;
    stage_addr_d = stage_addr_q;
    issue_vld_d  = 1'b0;
    drain_cnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          chan_d       = load_chan[CHAN_W-1:0];
          stage_addr_d = '0;
          issue_vld_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (!last_tap) begin
          stage_addr_d = stage_addr_q + TAP_W'(1);
          issue_vld_d  = 1'b1;
        end
      end
      DRAIN:   drain_cnt_d = drain_cnt_q + DRN_W'(1);
      default: ;
    endcase

    coef_we_d    = head_vld;
    coef_addr_d  = head_vld ? {chan_q, head_tap} : coef_addr_q;
    coef_data_d  = head_vld ? stage_data : coef_data_q;
    done_d       = head_vld && (head_tap == TAP_W'(N_TAPS - 1));
    done_count_d = done_d ? done_count_q + 16'd1 : done_count_q;
    overrun_d    = overrun_q || (req_edge && busy_int);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      prev_q       <= 1'b1;
      chan_q       <= '0;
      stage_addr_q <= '0;
      issue_vld_q  <= 1'b0;
      drain_cnt_q  <= '0;
      coef_we_q    <= 1'b0;
      coef_addr_q  <= '0;
      coef_data_q  <= '0;
      done_q       <= 1'b0;
      done_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      chan_q       <= chan_d;
      stage_addr_q <= stage_addr_d;
      issue_vld_q  <= issue_vld_d;
      drain_cnt_q  <= drain_cnt_d;
      coef_we_q    <= coef_we_d;
      coef_addr_q  <= coef_addr_d;
      coef_data_q  <= coef_data_d;
      done_q       <= done_d;
      done_count_q <= done_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign stage_addr = stage_addr_q;
  assign coef_we    = coef_we_q;
  assign coef_addr  = coef_addr_q;
  assign coef_data  = coef_data_q;
  assign busy       = busy_int;
  assign done       = done_q;
  assign done_count = done_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_prog_fir_coeff_loader.sv
// Bench for prog_fir_coeff_loader: staging BRAM model, request-level reference model and write scoreboard.
module tb_prog_fir_coeff_loader;

  localparam int N  = 20;
  localparam int TW = 5;
  localparam int CW = 8;
  localparam int DW = 18;
  localparam int RL = 2;

  logic             user_clk = 1'b0;
  logic             user_rst;
  logic [31:0]      load_chan;
  logic [TW-1:0]    stage_addr;
  logic [DW-1:0]    stage_data;
  logic             coef_we;
  logic [CW+TW-1:0] coef_addr;
  logic [DW-1:0]    coef_data;
  logic             busy;
  logic             done;
  logic [15:0]      done_count;
  logic             overrun;

  prog_fir_coeff_loader #(
    .N_TAPS (N), .TAP_W (TW), .CHAN_W (CW), .COEF_W (DW), .RD_LAT (RL)
  ) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .load_chan  (load_chan),
    .stage_addr (stage_addr),
    .stage_data (stage_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .busy       (busy),
    .done       (done),
    .done_count (done_count),
    .overrun    (overrun)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  // staging BRAM with RL-cycle registered read
  logic [DW-1:0] mem [2**TW];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge user_clk) begin
    rd_pipe[0] <= mem[stage_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign stage_data = rd_pipe[RL-1];

  typedef struct {
    int               cyc;
    logic [CW+TW-1:0] addr;
    logic [DW-1:0]    data;
  } wr_t;

  wr_t         got_wr[$], exp_wr[$];
  int          got_done_cyc[$], exp_done_cyc[$];
  logic [15:0] got_done_cnt[$], exp_done_cnt[$];
  logic        busy_log [20000];

  always @(negedge user_clk) begin
    if (coef_we === 1'b1) got_wr.push_back('{cyc, coef_addr, coef_data});
    if (done === 1'b1) begin
      got_done_cyc.push_back(cyc);
      got_done_cnt.push_back(done_count);
    end
    if (cyc < 20000) busy_log[cyc] = busy;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pack_wr(input wr_t w);
    return {1'b0, w.cyc, w.addr, w.data};
  endfunction

  // Reference model: a request edge either starts a whole load or, inside an active load window, is an overrun
  int          busy_end = -1;
  logic [15:0] m_count  = '0;
  logic        m_overrun = 1'b0;
  logic        m_prev   = 1'b1;

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] v);
    load_chan = v;
    if (v[31] && !m_prev) begin
      if (cyc <= busy_end) m_overrun = 1'b1;
      else begin
        for (int k = 0; k < N; k++)
          exp_wr.push_back('{cyc + 2 + RL + k, {v[CW-1:0], TW'(k)}, mem[k]});
        busy_end = cyc + 1 + N + RL;
        m_count  = m_count + 16'd1;
        exp_done_cyc.push_back(busy_end);
        exp_done_cnt.push_back(m_count);
      end
    end
    m_prev = v[31];
  endtask

  task automatic do_reset(input int n);
    int          c0 = cyc;
    wr_t         keep_wr[$];
    int          keep_dc[$];
    logic [15:0] keep_dn[$];
    user_rst = 1'b1;
    foreach (exp_wr[i]) if (exp_wr[i].cyc <= c0) keep_wr.push_back(exp_wr[i]);
    foreach (exp_done_cyc[i])
      if (exp_done_cyc[i] <= c0) begin
        keep_dc.push_back(exp_done_cyc[i]);
        keep_dn.push_back(exp_done_cnt[i]);
      end
    exp_wr       = keep_wr;
    exp_done_cyc = keep_dc;
    exp_done_cnt = keep_dn;
    busy_end  = -1;
    m_count   = '0;
    m_overrun = 1'b0;
    m_prev    = 1'b1;
    repeat (n) step();
    user_rst = 1'b0;
  endtask

  task automatic scoreboard(input string tag);
    check({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, pack_wr(got_wr[i]), pack_wr(exp_wr[i]));
    check({tag, "_ndone"}, 64'(got_done_cyc.size()), 64'(exp_done_cyc.size()));
    for (int i = 0; i < got_done_cyc.size() && i < exp_done_cyc.size(); i++)
      check({tag, "_done"}, {got_done_cnt[i], 32'(got_done_cyc[i])},
            {exp_done_cnt[i], 32'(exp_done_cyc[i])});
    check({tag, "_overrun"}, 64'(overrun), 64'(m_overrun));
    check({tag, "_count"}, 64'(done_count), 64'(m_count));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    got_wr.delete(); exp_wr.delete();
    got_done_cyc.delete(); exp_done_cyc.delete();
    got_done_cnt.delete(); exp_done_cnt.delete();
  endtask

  typedef struct {
    int   g1;
    int   g2;
    logic exp_ovr;
    int   exp_loads;
  } edge_vec_t;

  initial begin
    edge_vec_t tbl[4];
    int t;
    tbl[0] = '{10, 24, 1'b1, 2};
    tbl[1] = '{23, 0,  1'b1, 1};
    tbl[2] = '{24, 0,  1'b0, 2};
    tbl[3] = '{30, 0,  1'b0, 2};

    for (int k = 0; k < 2**TW; k++) mem[k] = DW'(32'h100 + k);
    user_rst  = 1'b1;
    load_chan = '0;
    do_reset(3);

    check("rst_stage_addr", 64'(stage_addr), 64'd0);
    check("rst_coef_we",    64'(coef_we),    64'd0);
    check("rst_coef_addr",  64'(coef_addr),  64'd0);
    check("rst_coef_data",  64'(coef_data),  64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    check("rst_overrun",    64'(overrun),    64'd0);

    // basic load of channel 5
    drive(32'h0);
    step();
    drive(32'h8000_0005);
    t = cyc;
    repeat (30) step();
    check("basic_first_wr", 64'(got_wr.size() > 0 ? got_wr[0].cyc : -1), 64'(t + 4));
    check("basic_first_addr", 64'(got_wr.size() > 0 ? got_wr[0].addr : 0), 64'({8'd5, 5'd0}));
    check("basic_done_cyc", 64'(got_done_cyc.size() > 0 ? got_done_cyc[0] : -1), 64'(t + 23));
    check("basic_busy_T",   64'(busy_log[t]),      64'd0);
    check("basic_busy_T1",  64'(busy_log[t + 1]),  64'd1);
    check("basic_busy_T23", 64'(busy_log[t + 23]), 64'd1);
    check("basic_busy_T24", 64'(busy_log[t + 24]), 64'd0);
    check("basic_count", 64'(done_count), 64'd1);
    scoreboard("basic");

    // request bit high across reset must not trigger
    drive(32'h0);
    step();
    drive(32'h8000_0003);
    do_reset(2);
    repeat (30) step();
    check("held_no_wr", 64'(got_wr.size()), 64'd0);
    scoreboard("held");
    drive(32'h0);
    step();
    drive(32'h8000_0003);
    repeat (30) step();
    check("held_reload_addr", 64'(got_wr.size() > 0 ? got_wr[0].addr : 0), 64'({8'd3, 5'd0}));
    scoreboard("held_reload");

    // edge-timing table: first load to channel 2, later edges to channel 7
    for (int e = 0; e < 4; e++) begin
      do_reset(2);
      drive(32'h0);
      step();
      drive(32'h8000_0002);
      t = cyc;
      for (int off = 1; off <= 60; off++) begin
        step();
        drive((off == tbl[e].g1 || off == tbl[e].g2) ? 32'h8000_0007 : 32'h0000_0007);
      end
      check($sformatf("tbl%0d_overrun", e), 64'(overrun), 64'(tbl[e].exp_ovr));
      check($sformatf("tbl%0d_count", e), 64'(done_count), 64'(tbl[e].exp_loads));
      scoreboard($sformatf("tbl%0d", e));
    end

    // reset in the middle of a load
    do_reset(2);
    drive(32'h0);
    step();
    drive(32'h8000_0009);
    t = cyc;
    repeat (8) step();
    do_reset(1);
    repeat (30) step();
    check("midrst_busy", 64'(busy_log[t + 9]), 64'd0);
    check("midrst_nwr",  64'(got_wr.size()), 64'd5);
    check("midrst_done", 64'(got_done_cyc.size()), 64'd0);
    scoreboard("midrst");

    // done_count wrap
    do_reset(2);
    force dut.done_count_q = 16'hFFFF;
    #1;
    release dut.done_count_q;
    m_count = 16'hFFFF;
    drive(32'h0);
    step();
    drive(32'h8000_0004);
    repeat (30) step();
    check("wrap_count", 64'(done_count), 64'd0);
    check("wrap_done_cnt", 64'(got_done_cnt.size() > 0 ? got_done_cnt[0] : 16'h1234), 64'd0);
    scoreboard("wrap");

    // randomized request traffic against the reference model
    do_reset(2);
    for (int k = 0; k < 2**TW; k++) mem[k] = DW'($urandom);
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) drive($urandom);
      else drive(load_chan);
    end
    step();
    drive(32'h0);
    repeat (40) step();
    scoreboard("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
